// File: rtl/datapath.sv
// Execution datapath of the 8-bit microcontroller. It holds the PC, IR, a 16 x 8 register file,
// the accumulator, the ALU and the Z/C flags, and it answers the controller's load/select strobes.
module datapath #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       LoadIR,
  input  logic       IncPC,
  input  logic       SelPC,
  input  logic       LoadPC,
  input  logic       LoadReg,
  input  logic       LoadAcc,
  input  logic [1:0] SelAcc,
  input  logic [3:0] SelALU,
  input  logic [7:0] InstrData,
  output logic [7:0] PCAddr,
  output logic [7:0] Opcode,
  output logic       Z,
  output logic       C,
  output logic [7:0] AccOut
);

  localparam int NREGS = 16;

  typedef enum logic [3:0] {
    ALU_PASS_B = 4'b0000,
    ALU_PASS_A = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0011,
    ALU_NOR    = 4'b0100,
    ALU_AND    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_XOR    = 4'b0111,
    ALU_SHL    = 4'b1000,
    ALU_SHR    = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ACC_ZERO = 2'b00,
    ACC_IMM  = 2'b01,
    ACC_ALU  = 2'b10,
    ACC_REG  = 2'b11
  } acc_sel_e;

  logic [7:0] pc_q,  pc_d;
  logic [7:0] ir_q,  ir_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q,   z_d;
  logic       c_q,   c_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];

  logic [3:0] reg_idx;
  logic [7:0] reg_b;
  logic [7:0] imm;
  logic [7:0] alu_r;
  logic       alu_k;

  assign reg_idx = ir_q[3:0];
  assign reg_b   = regs_q[reg_idx];
  assign imm     = {4'h0, ir_q[3:0]};

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_r = acc_q;
    alu_k = 1'b0;
    case (SelALU)
      ALU_PASS_B: alu_r = reg_b;
      ALU_PASS_A: alu_r = acc_q;
      ALU_ADD:    {alu_k, alu_r} = {1'b0, acc_q} + {1'b0, reg_b};
      ALU_SUB: begin
        alu_r = acc_q - reg_b;
        alu_k = (acc_q < reg_b);
      end
      ALU_NOR:    alu_r = ~(acc_q | reg_b);
      ALU_AND:    alu_r = acc_q & reg_b;
      ALU_OR:     alu_r = acc_q | reg_b;
      ALU_XOR:    alu_r = acc_q ^ reg_b;
      ALU_SHL: begin
        alu_r = {acc_q[6:0], 1'b0};
        alu_k = acc_q[7];
      end
      ALU_SHR: begin
        alu_r = {1'b0, acc_q[7:1]};
        alu_k = acc_q[0];
      end
      default: alu_r = acc_q;
    endcase
  end

  // Every destination reads only _q values, so simultaneous strobes see pre-edge state.
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    acc_d  = acc_q;
    z_d    = z_q;
    c_d    = c_q;
    regs_d = regs_q;

    if (LoadPC)     pc_d = SelPC ? imm : reg_b;
    else if (IncPC) pc_d = pc_q + 8'd1;

    if (LoadIR)  ir_d = InstrData;
    if (LoadReg) regs_d[reg_idx] = acc_q;

    if (LoadAcc) begin
      case (SelAcc)
        ACC_ZERO: acc_d = 8'h00;
        ACC_IMM:  acc_d = imm;
        ACC_ALU: begin
          acc_d = alu_r;
          z_d   = (alu_r == 8'h00);
          c_d   = alu_k;
        end
        default:  acc_d = reg_b;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge CLK) begin
    if (!CLB) begin
      pc_q  <= PC_RESET;
      ir_q  <= 8'h00;
      acc_q <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      // NOTE: the register file is cleared on reset, so it is built from resettable flops, not a RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      acc_q  <= acc_d;
      z_q    <= z_d;
      c_q    <= c_d;
      regs_q <= regs_d;
    end
  end

  assign PCAddr = pc_q;
  assign Opcode = ir_q;
  assign Z      = z_q;
  assign C      = c_q;
  assign AccOut = acc_q;

endmodule

// File: doc/datapath.md
# datapath

Execution datapath of the 8-bit microcontroller. It is the other end of the controller's control interface: it consumes LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc and SelALU, and returns Opcode, Z and C to the controller. It holds the program counter, instruction register, a 16 x 8 register file, the accumulator, the ALU and the flag registers, and drives the instruction-memory address.

## Interface
- PC_RESET, 8'h00, program counter value after reset
- NREGS, 16, register file depth; fixed by the 4-bit register field IR[3:0]
- CLK  in  1  system clock; all state updates on the rising edge
- CLB  in  1  reset, synchronous, active-low; sampled on the CLK rising edge
- LoadIR  in  1  load IR from InstrData
- IncPC  in  1  PC <= PC + 1
- SelPC  in  1  PC load source: 0 = Reg[IR[3:0]], 1 = {4'h0, IR[3:0]}
- LoadPC  in  1  load PC from the SelPC source
- LoadReg  in  1  Reg[IR[3:0]] <= Acc
- LoadAcc  in  1  load Acc from the SelAcc source
- SelAcc  in  2  Acc source: 00 = 8'h00, 01 = {4'h0, IR[3:0]}, 10 = ALU result, 11 = Reg[IR[3:0]]
- SelALU  in  4  ALU operation (see Operation)
- InstrData  in  8  instruction-memory read data for address PCAddr
- PCAddr  out  8  current PC, registered
- Opcode  out  8  current IR contents, registered
- Z  out  1  zero flag, registered
- C  out  1  carry/borrow flag, registered
- AccOut  out  8  current accumulator value, for debug and observation

## Operation
- Reset (CLB = 0 at a rising edge):
  - PC <= PC_RESET; IR, Acc and every register-file entry <= 8'h00; Z <= 0; C <= 0.
  - Reset overrides every control input asserted in the same cycle.
  - Reset mid-instruction discards all pending updates.
- ALU operands: A = Acc, B = Reg[IR[3:0]]. Operands are read combinationally from the current register values.
- SelALU encoding, result R and carry-out K:
  - 0000: pass B, K = 0
  - 0001: pass A, K = 0
  - 0010: ADD, {K, R} = A + B (9-bit sum)
  - 0011: SUB, R = A - B mod 256, K = 1 when A < B (borrow)
  - 0100: NOR, K = 0
  - 0101: AND, K = 0
  - 0110: OR, K = 0
  - 0111: XOR, K = 0
  - 1000: SHL, R = {A[6:0], 0}, K = A[7]
  - 1001: SHR, R = {0, A[7:1]}, K = A[0]
  - 1010-1111: pass A, K = 0
- Flags:
  - Z and C update only when LoadAcc = 1 and SelAcc = 10: Z <= (R == 0), C <= K.
  - Every other Acc load, and every cycle without LoadAcc, leaves Z and C unchanged.
- PC:
  - LoadPC has priority over IncPC.
  - Increment wraps from 8'hFF to 8'h00.
  - The immediate jump target is zero-extended IR[3:0].
- IR: loads InstrData, the word at the pre-update PCAddr. A simultaneous IncPC does not change the word captured.
- Simultaneous LoadReg and LoadAcc: the register file captures the old Acc; Acc captures its new source (read-before-write on the same edge).
- LoadReg with SelAcc = 11 on the same index: Acc captures the old register value.
- Any combination of load strobes is legal; each destination follows its own strobe independently.

## Timing
- Single-cycle register transfers: a strobe sampled at edge N makes the new value visible on the outputs after edge N.
- Opcode is valid on the cycle after LoadIR. It is a registered output with no combinational path from InstrData.
- Z and C change on the same edge as Acc.
- The ALU path is combinational from Acc/register file/IR to the Acc D-input. It must close timing within one CLK period.
- PCAddr is registered. InstrData is expected to be combinational, or valid in the cycle PCAddr is presented.
- No handshake: the controller owns sequencing. The datapath holds all state whenever every strobe is low.

## Test plan
- Reset: run with random strobes, then CLB = 0 for 1 cycle -> PCAddr = 00, Opcode = 00, AccOut = 00, Z = 0, C = 0; Reg[5] reads 00 via SelAcc = 11.
- Fetch/increment: InstrData = 8'h23, LoadIR = 1 and IncPC = 1 at PC = 00 -> Opcode = 23, PCAddr = 01. With PC = FF and IncPC -> PCAddr = 00.
- ADD carry: Acc = F0, Reg[3] = 20, IR[3:0] = 3, SelALU = 0010, SelAcc = 10, LoadAcc -> Acc = 10, C = 1, Z = 0. Then SUB 10 - 20 -> Acc = F0, C = 1. Then SUB 20 - 20 -> Acc = 00, Z = 1, C = 0.
- Flag hold: after Z = 1, load Acc via SelAcc = 01 with IR = x7 -> Acc = 07, Z stays 1, C unchanged.
- Jumps: IR = 8'h_4, LoadPC, SelPC = 1 -> PC = 04. Reg[4] = 9A, SelPC = 0 -> PC = 9A. LoadPC and IncPC together -> loaded value wins.
- Read-before-write: Acc = 55, Reg[2] = AA, IR[3:0] = 2, LoadReg = 1 and LoadAcc = 1 with SelAcc = 11 -> Reg[2] = 55, Acc = AA.
